inst_fetch_buffer: RTL

Parametrised instruction-fetch front end between the PC generator and instruction memory. It is the next generation of the fixed 32-bit PC/instruction exchange. It issues pipelined in-order fetch requests with a valid/ready handshake and buffers returned instructions in a DEPTH-entry queue. It delivers {pc, next_pc, ins, rs1, rs2, rd} to decode under valid/ready, and discards in-flight fetches on a redirect.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/inst_fetch_buffer_if.sv | 39 +++
 rtl/inst_fetch_buffer_sync_fifo.sv | 67 ++++++
 rtl/inst_fetch_buffer.sv | 122 ++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and helpers for the instruction fetch buffer
package fetch_pkg;

    localparam int ILEN      = 32;
    localparam int INS_BYTES = 4;
    localparam int REG_W     = 5;

    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int RD_LSB  = 7;

    function automatic logic [REG_W-1:0] reg_field(input logic [ILEN-1:0] ins, input int lsb);
        logic [ILEN-1:0] shifted;
        shifted = ins >> lsb;
        return shifted[REG_W-1:0];
    endfunction

endpackage

// File: rtl/inst_fetch_buffer_if.sv
// rtl/inst_fetch_buffer_if.sv - memory, redirect and decode handshakes of the fetch buffer
interface inst_fetch_buffer_if #(
    parameter int XLEN = 32
);
    import fetch_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [XLEN-1:0]   req_addr;
    logic              rsp_valid;
    logic [ILEN-1:0]   rsp_ins;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    logic [XLEN-1:0]   out_next_pc;
    logic [ILEN-1:0]   out_ins;
    logic [REG_W-1:0]  out_rs1;
    logic [REG_W-1:0]  out_rs2;
    logic [REG_W-1:0]  out_rd;

    modport master (
        output req_valid, req_addr,
        input  req_ready, rsp_valid, rsp_ins,
        input  redirect_valid, redirect_pc,
        output out_valid, out_pc, out_next_pc, out_ins, out_rs1, out_rs2, out_rd,
        input  out_ready
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready, rsp_valid, rsp_ins,
        output redirect_valid, redirect_pc,
        input  out_valid, out_pc, out_next_pc, out_ins, out_rs1, out_rs2, out_rd,
        output out_ready
    );

endinterface

// File: rtl/inst_fetch_buffer_sync_fifo.sv
// rtl/inst_fetch_buffer_sync_fifo.sv - power-of-two FIFO with synchronous clear and occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/inst_fetch_buffer.sv
// rtl/inst_fetch_buffer.sv - credit-limited in-order fetch front end with redirect flush
module inst_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    inst_fetch_buffer_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] next_pc;
        logic [ILEN-1:0] ins;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    logic [XLEN-1:0]    pc_q, pc_d;
    logic [CW-1:0]      o_q, o_d;
    logic [CW-1:0]      d_q, d_d;
    logic [CW-1:0]      q_count, tag_count;
    logic               q_empty, q_full, tag_empty, tag_full;
    logic [ENTRY_W-1:0] q_head_raw;
    logic [XLEN-1:0]    tag_head;
    fetch_entry_t       push_entry, head;
    logic [CW:0]        in_use;
    logic               issue, keep, drop, pop;
    logic               unused_status;

    // Queue slots plus outstanding requests never exceed DEPTH, so a response always has a slot.
    assign in_use        = {1'b0, q_count} + {1'b0, o_q};
    assign bus.req_valid = rst_n && !bus.redirect_valid && (in_use < (CW+1)'(DEPTH));
    assign bus.req_addr  = pc_q;

    assign issue = bus.req_valid && bus.req_ready;
    assign drop  = bus.rsp_valid && (d_q != '0);
    assign keep  = bus.rsp_valid && (d_q == '0) && !bus.redirect_valid;

    assign bus.out_valid = !q_empty && !bus.redirect_valid;
    assign pop           = bus.out_valid && bus.out_ready;

    always_comb begin
        push_entry.pc      = tag_head;
        push_entry.next_pc = tag_head + XLEN'(INS_BYTES);
        push_entry.ins     = bus.rsp_ins;
    end

    always_comb begin
        pc_d = pc_q;
        o_d  = o_q + CW'(issue) - CW'(bus.rsp_valid);
        d_d  = d_q;
        if (bus.redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old path.
            pc_d = bus.redirect_pc;
            d_d  = o_q - CW'(bus.rsp_valid);
        end else begin
            if (issue) pc_d = pc_q + XLEN'(INS_BYTES);
            if (drop)  d_d  = d_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
            o_q  <= '0;
            d_q  <= '0;
        end else begin
            pc_q <= pc_d;
            o_q  <= o_d;
            d_q  <= d_d;
        end
    end

    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (bus.redirect_valid),
        .push_i      (issue),
        .push_data_i (pc_q),
        .pop_i       (keep),
        .head_o      (tag_head),
        .empty_o     (tag_empty),
        .full_o      (tag_full),
        .count_o     (tag_count)
    );

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_entry_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (bus.redirect_valid),
        .push_i      (keep),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (q_head_raw),
        .empty_o     (q_empty),
        .full_o      (q_full),
        .count_o     (q_count)
    );

    assign unused_status = ^{tag_count, tag_empty, tag_full, q_full};

    assign head            = fetch_entry_t'(q_head_raw);
    assign bus.out_pc      = head.pc;
    assign bus.out_next_pc = head.next_pc;
    assign bus.out_ins     = head.ins;
    assign bus.out_rs1     = reg_field(head.ins, RS1_LSB);
    assign bus.out_rs2     = reg_field(head.ins, RS2_LSB);
    assign bus.out_rd      = reg_field(head.ins, RD_LSB);

endmodule
